mux_pipeline: RTL
=================

// Module: mux_pipeline
// PURPOSE
//  Pipelined N:1 multiplexer with fixed, parameterised output latency; gather-side
//  counterpart to the pipelined demux. Selects one of INPUT_COUNT words of width WIDTH
//  through a tree of MUX_SIZE:1 stages, one register rank per tree level.
//  A valid bit and the stage select slices travel alongside the data.
//  Used in high-fmax paths where a wide mux cannot close timing in one cycle.
// PARAMETERS
//  WIDTH        1  bits per data word
//  INPUT_COUNT  2  number of input words (>=2)
//  LATENCY      0  clk cycles from in/sel/in_valid sample to out/out_valid; 0 = combinational
//  PRINT        0  !=0 prints derived structure sizes at elaboration
// PORTS
//  clk        in   1                    clock; all registers update on posedge
//  rst        in   1                    asynchronous, active-high reset
//  ce         in   1                    clock enable; 0 freezes every pipeline register
//  sel        in   clog2(INPUT_COUNT)   index of word to pass
//  in         in   WIDTH*INPUT_COUNT    packed inputs, word i at in[i*WIDTH+:WIDTH]
//  in_valid   in   1                    qualifies sel/in this cycle
//  out        out  WIDTH                selected word, LATENCY cycles later
//  out_valid  out  1                    in_valid delayed LATENCY cycles
// BEHAVIOUR
//  - Derived: MUX_SIZE = 2^clog2(ceil(INPUT_COUNT^(1/LATENCY))) (LATENCY>0);
//    SEL_WIDTH = clog2(MUX_SIZE); DEPTH = ceil(log_MUX_SIZE(INPUT_COUNT)).
//  - LATENCY>DEPTH: (LATENCY-DEPTH) delay ranks precede the tree on {in,sel,in_valid}.
//  - Tree level k consumes sel[k*SEL_WIDTH+:SEL_WIDTH], LSB slice at the first level;
//    the unused upper sel slices are registered with the data for the later levels.
//  - Unpopulated leaf positions (index >= INPUT_COUNT) read as zero; sel >= INPUT_COUNT
//    -> out = 0 after LATENCY, out_valid still follows in_valid.
//  - Fixed latency for every sel value; no stall path other than ce; throughput 1/cycle.
//  - out is data-path only: out is not masked by out_valid; bench compares only when valid.
//  - ce=0: all ranks (data, sel, valid) hold; out/out_valid constant. ce=1 shifts one rank.
//  - rst asserted (any time, incl. mid-stream): all ranks clear immediately;
//    out=0, out_valid=0 while rst high; in-flight words are discarded, none re-emitted.
//  - After rst deasserts: first out_valid=1 exactly LATENCY ce=1 cycles after the first
//    sampled in_valid=1.
//  - LATENCY=0: purely combinational: out = in[sel], out_valid = in_valid;
//    rst and ce have no effect.
//  - Back-to-back different sel values each cycle -> each result emerges in order,
//    no cross-talk between words in adjacent ranks.
// TESTING
//  1 W=8,N=5,L=2 (MUX_SIZE=4,DEPTH=2): in={44,33,22,11,00}h, sel=3,
//    in_valid=1 at cyc0 -> out=33h, out_valid=1 at cyc2.
//  2 Same cfg, sel=0,1,2,3,4 on cyc0..4, in_valid=1 throughout ->
//    out=00,11,22,33,44h on cyc2..6, out_valid=1 each.
//  3 Same cfg, sel=7 (out of range), in_valid=1 -> out=00h, out_valid=1 two cycles later.
//  4 Same cfg, sel=4 at cyc0, ce=0 on cyc1..3 -> out=44h, out_valid=1 at cyc5;
//    values held during the stall.
//  5 Same cfg, stream running, rst pulsed mid-cycle at cyc3 -> out=0, out_valid=0
//    asynchronously; no stale word after release.
//  6 W=4,N=16,L=4 (DEPTH=4) and W=4,N=3,L=0: random sel/in 1000 cycles vs.
//    delayed golden model -> zero mismatches when out_valid=1.

Source files
------------

// File: rtl/mux_pipeline.sv
// rtl/mux_pipeline.sv - pipelined N:1 multiplexer with fixed latency
// Tree of MUX_SIZE:1 stages, one register rank per level, optional leading delay ranks.
module mux_pipeline #(
  parameter int WIDTH       = 1,
  parameter int INPUT_COUNT = 2,
  parameter int LATENCY     = 0,
  parameter int PRINT       = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_ce,
  input  logic [$clog2(INPUT_COUNT)-1:0] i_sel,
  input  logic [WIDTH*INPUT_COUNT-1:0]   i_in,
  input  logic                           i_in_valid,
  output logic [WIDTH-1:0]               o_out,
  output logic                           o_out_valid
);

  localparam int SELW_IN   = $clog2(INPUT_COUNT);
  localparam int SEL_WIDTH = (LATENCY == 0) ? 1 : (SELW_IN + LATENCY - 1) / LATENCY;
  localparam int MUX_SIZE  = 1 << SEL_WIDTH;
  localparam int DEPTH     = (LATENCY == 0) ? 0 : (SELW_IN + SEL_WIDTH - 1) / SEL_WIDTH;
  localparam int SEL_TOT   = (DEPTH == 0) ? SELW_IN : DEPTH * SEL_WIDTH;
  localparam int TREE_W    = (1 << SEL_TOT) * WIDTH;
  localparam int PRE       = LATENCY - DEPTH;

  if (PRINT != 0) begin : g_print
    $info("mux_pipeline: MUX_SIZE=%0d SEL_WIDTH=%0d DEPTH=%0d PRE=%0d",
          MUX_SIZE, SEL_WIDTH, DEPTH, PRE);
  end

  if (LATENCY == 0) begin : g_comb
    logic [TREE_W-1:0] w_flat;
    logic              w_unused;
    // Zero-extension makes out-of-range selects read as zero.
    assign w_flat      = TREE_W'(i_in);
    assign o_out       = w_flat[i_sel*WIDTH +: WIDTH];
    assign o_out_valid = i_in_valid;
    assign w_unused    = ^{i_clk, i_rst, i_ce};
  end else begin : g_pipe
    logic [WIDTH*INPUT_COUNT-1:0] w_pin;
    logic [SELW_IN-1:0]           w_psel;
    logic                         w_pvalid;
    logic [TREE_W-1:0]            w_tree_d;
    logic [SEL_TOT-1:0]           w_tree_s;
    logic                         w_tree_v;

    if (PRE > 0) begin : g_pre
      logic [WIDTH*INPUT_COUNT-1:0] r_in    [PRE];
      logic [SELW_IN-1:0]           r_sel   [PRE];
      logic                         r_valid [PRE];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < PRE; i++) begin
            r_in[i]    <= '0;
            r_sel[i]   <= '0;
            r_valid[i] <= 1'b0;
          end
        end else if (i_ce) begin
          r_in[0]    <= i_in;
          r_sel[0]   <= i_sel;
          r_valid[0] <= i_in_valid;
          for (int i = 1; i < PRE; i++) begin
            r_in[i]    <= r_in[i-1];
            r_sel[i]   <= r_sel[i-1];
            r_valid[i] <= r_valid[i-1];
          end
        end
      end

      assign w_pin    = r_in[PRE-1];
      assign w_psel   = r_sel[PRE-1];
      assign w_pvalid = r_valid[PRE-1];
    end else begin : g_nopre
      assign w_pin    = i_in;
      assign w_psel   = i_sel;
      assign w_pvalid = i_in_valid;
    end

    assign w_tree_d = TREE_W'(w_pin);
    assign w_tree_s = SEL_TOT'(w_psel);
    assign w_tree_v = w_pvalid;

    for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
      localparam int CIN  = MUX_SIZE ** (DEPTH - k);
      localparam int COUT = CIN / MUX_SIZE;
      localparam int SIN  = SEL_TOT - k * SEL_WIDTH;
      localparam int SOUT = SIN - SEL_WIDTH;

      logic [CIN*WIDTH-1:0]  w_din;
      logic [SIN-1:0]        w_sin;
      logic                  w_vin;
      logic [COUT*WIDTH-1:0] w_mux;
      logic [COUT*WIDTH-1:0] r_data;
      logic                  r_valid;

      if (k == 0) begin : g_src
        assign w_din = w_tree_d;
        assign w_sin = w_tree_s;
        assign w_vin = w_tree_v;
      end else begin : g_src
        assign w_din = g_lvl[k-1].r_data;
        assign w_sin = g_lvl[k-1].g_sel.r_sel;
        assign w_vin = g_lvl[k-1].r_valid;
      end

      // Each level resolves the lowest remaining select slice.
      always_comb begin
        w_mux = '0;
        for (int j = 0; j < COUT; j++)
          w_mux[j*WIDTH +: WIDTH] = w_din[(j*MUX_SIZE + int'(w_sin[SEL_WIDTH-1:0]))*WIDTH +: WIDTH];
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (i_ce) begin
          r_data  <= w_mux;
          r_valid <= w_vin;
        end
      end

      if (k < DEPTH - 1) begin : g_sel
        logic [SOUT-1:0] r_sel;
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst)     r_sel <= '0;
          else if (i_ce) r_sel <= w_sin[SIN-1:SEL_WIDTH];
        end
      end
    end

    assign o_out       = g_lvl[DEPTH-1].r_data;
    assign o_out_valid = g_lvl[DEPTH-1].r_valid;
  end

endmodule
